lcd_num_writer: RTL and testbench

Formats a 16-bit unsigned value as 5 decimal ASCII characters and writes them into the LCD character RAM of the LCD controller through its write port (`W`, `WADD`, `DIN`). It sits directly upstream of the LCD controller. Producers such as sensor readouts and HIL status counters issue one start pulse per number and never touch the RAM port themselves. Conversion uses iterative subtraction, with no dividers, and writes go out one character per clock.

---
 rtl/lcd_num_writer_if.sv | 42 ++++
 rtl/lcd_num_writer.sv | 144 ++++++++++++++
 tb/tb_lcd_num_writer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_num_writer_if.sv
// Handshake and LCD RAM write-port bundle for lcd_num_writer.
//   start : request pulse from the producer (sampled only when idle)
//   value : 16-bit unsigned number to format
//   pos   : LCD RAM address of the most significant character
//   busy  : writer occupied, from the cycle after acceptance through DONE
//   done  : one-cycle pulse after the fifth character is written
//   W     : LCD RAM write strobe
//   WADD  : LCD RAM address
//   DIN   : ASCII character
// The slave modport is the writer; the master modport is the producer/observer side.
interface lcd_num_writer_if;
   logic        start;
   logic [15:0] value;
   logic [4:0]  pos;
   logic        busy;
   logic        done;
   logic        W;
   logic [4:0]  WADD;
   logic [7:0]  DIN;

   modport slave (
      input  start,
      input  value,
      input  pos,
      output busy,
      output done,
      output W,
      output WADD,
      output DIN
   );

   modport master (
      output start,
      output value,
      output pos,
      input  busy,
      input  done,
      input  W,
      input  WADD,
      input  DIN
   );
endinterface

// File: rtl/lcd_num_writer.sv
// lcd_num_writer: formats a 16-bit unsigned value as five decimal ASCII characters
// by iterative subtraction and writes them, one per clock, MSD first, into the LCD
// controller character RAM.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : lcd_num_writer_if.slave (start/value/pos in; busy/done/W/WADD/DIN out)
// Parameter:
//   LEAD_BLANK : when 1, leading zeros are written as spaces (last digit always numeral)
module lcd_num_writer #(
   parameter bit LEAD_BLANK = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   lcd_num_writer_if.slave   bus
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StConv  = 2'd1;
   localparam logic [1:0] StWrite = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   logic [1:0]       state_q;
   logic [16:0]      rem_q;
   logic [4:0]       base_q;
   logic [2:0]       k_q;
   logic [3:0]       cnt_q;
   logic [4:0][3:0]  digit_q;
   logic [2:0]       i_q;
   logic             busy_q;
   logic             done_q;
   logic             w_q;
   logic [4:0]       wadd_q;
   logic [7:0]       din_q;

   logic [16:0]      weight;
   logic [7:0]       char_first;
   logic [7:0]       char_next;

   // Character for digit idx; blank while every digit up to idx is zero.
   function automatic logic [7:0] char_of(input logic [2:0] idx, input logic [4:0][3:0] dig);
      logic       lead;
      logic [3:0] d;
      lead = 1'b1;
      d    = 4'd0;
      for (int j = 0; j < 5; j++) begin
         if (3'(j) <= idx) begin
            lead = lead & (dig[j] == 4'd0);
            if (3'(j) == idx) d = dig[j];
         end
      end
      if (LEAD_BLANK && (idx < 3'd4) && lead) return 8'h20;
      return {4'h3, d};
   endfunction

   always_comb begin
      weight = 17'd1;
      case (k_q)
         3'd0:    weight = 17'd10000;
         3'd1:    weight = 17'd1000;
         3'd2:    weight = 17'd100;
         3'd3:    weight = 17'd10;
         default: weight = 17'd1;
      endcase
   end

   // Digit 0 is already stored when the last CONV cycle launches the first write.
   always_comb begin
      char_first = char_of(3'd0, digit_q);
      char_next  = char_of(i_q + 3'd1, digit_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         rem_q   <= '0;
         base_q  <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         digit_q <= '0;
         i_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         w_q     <= 1'b0;
         wadd_q  <= '0;
         din_q   <= '0;
      end else begin
         done_q <= 1'b0;
         w_q    <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  rem_q   <= {1'b0, bus.value};
                  base_q  <= bus.pos;
                  k_q     <= 3'd0;
                  cnt_q   <= 4'd0;
                  busy_q  <= 1'b1;
                  state_q <= StConv;
               end
            end
            StConv: begin
               if (rem_q >= weight) begin
                  rem_q <= rem_q - weight;
                  cnt_q <= cnt_q + 4'd1;
               end else begin
                  digit_q[k_q] <= cnt_q;
                  cnt_q        <= 4'd0;
                  k_q          <= k_q + 3'd1;
                  if (k_q == 3'd4) begin
                     // Outputs are registered, so the first write is launched here.
                     state_q <= StWrite;
                     i_q     <= 3'd0;
                     w_q     <= 1'b1;
                     wadd_q  <= base_q;
                     din_q   <= char_first;
                  end
               end
            end
            StWrite: begin
               if (i_q != 3'd4) begin
                  w_q    <= 1'b1;
                  wadd_q <= base_q + 5'(i_q) + 5'd1;
                  din_q  <= char_next;
                  i_q    <= i_q + 3'd1;
               end else begin
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.W    = w_q;
   assign bus.WADD = wadd_q;
   assign bus.DIN  = din_q;

endmodule

// File: tb/tb_lcd_num_writer.sv
module tb_lcd_num_writer;

   logic clk;
   logic rst_n;

   lcd_num_writer_if bus0 ();
   lcd_num_writer_if bus1 ();

   lcd_num_writer #(.LEAD_BLANK(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
   );

   lcd_num_writer #(.LEAD_BLANK(1'b0)) dut_nb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int done0    = 0;
   int done1    = 0;

   // Scoreboards of {addr, char}, one per instance.
   logic [12:0] q0[$];
   logic [12:0] q1[$];

   function automatic logic [7:0] exp_char(input int v, input int i, input bit lb);
      int pw;
      int d;
      pw = 1;
      for (int j = 0; j < 4 - i; j++) pw = pw * 10;
      d = (v / pw) % 10;
      if (lb && i < 4 && v < pw) return 8'h20;
      return 8'(8'h30 + d);
   endfunction

   function automatic int digit_sum(input int v);
      int s;
      s = 0;
      for (int j = 0; j < 5; j++) begin
         s = s + v % 10;
         v = v / 10;
      end
      return s;
   endfunction

   task automatic push_exp(input bit nb, input int v, input logic [4:0] p, input int n);
      logic [4:0] a;
      for (int i = 0; i < n; i++) begin
         a = p + 5'(i);
         if (nb) q1.push_back({a, exp_char(v, i, 1'b0)});
         else    q0.push_back({a, exp_char(v, i, 1'b1)});
      end
   endtask

   // Write monitor: every observed write must match the head of its scoreboard.
   always @(negedge clk) begin
      logic [12:0] e;
      if (bus0.W === 1'b1) begin
         n_checks++;
         if (q0.size() == 0) begin
            n_fail++;
            $display("FAIL write0_unexpected got addr=%0d data=%h required no write",
                     bus0.WADD, bus0.DIN);
         end else begin
            e = q0.pop_front();
            if ({bus0.WADD, bus0.DIN} !== e) begin
               n_fail++;
               $display("FAIL write0 got addr=%0d data=%h required addr=%0d data=%h",
                        bus0.WADD, bus0.DIN, e[12:8], e[7:0]);
            end
         end
      end
      if (bus1.W === 1'b1) begin
         n_checks++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL write1_unexpected got addr=%0d data=%h required no write",
                     bus1.WADD, bus1.DIN);
         end else begin
            e = q1.pop_front();
            if ({bus1.WADD, bus1.DIN} !== e) begin
               n_fail++;
               $display("FAIL write1 got addr=%0d data=%h required addr=%0d data=%h",
                        bus1.WADD, bus1.DIN, e[12:8], e[7:0]);
            end
         end
      end
      if (bus0.done === 1'b1) done0++;
      if (bus1.done === 1'b1) done1++;
   end

   task automatic drive_start(input bit nb, input logic [15:0] v, input logic [4:0] p);
      @(negedge clk);
      if (nb) begin bus1.start = 1'b1; bus1.value = v; bus1.pos = p; end
      else    begin bus0.start = 1'b1; bus0.value = v; bus0.pos = p; end
      @(negedge clk);
      bus0.start = 1'b0;
      bus1.start = 1'b0;
   endtask

   // One full number: checks busy length, single done pulse, all writes consumed.
   task automatic run_num(input bit nb, input logic [15:0] v, input logic [4:0] p,
                          input string name);
      int cyc;
      int d0;
      bit b;
      push_exp(nb, int'(v), p, 5);
      d0 = nb ? done1 : done0;
      drive_start(nb, v, p);
      cyc = 0;
      while (cyc < 200) begin
         b = nb ? bus1.busy : bus0.busy;
         if (!b) break;
         cyc++;
         @(negedge clk);
      end
      n_checks++;
      if (cyc != digit_sum(int'(v)) + 11) begin
         n_fail++;
         $display("FAIL %s_busy_cycles got %0d required %0d", name, cyc,
                  digit_sum(int'(v)) + 11);
      end
      n_checks++;
      if ((nb ? done1 : done0) - d0 != 1) begin
         n_fail++;
         $display("FAIL %s_done_pulses got %0d required 1", name, (nb ? done1 : done0) - d0);
      end
      n_checks++;
      if ((nb ? q1.size() : q0.size()) != 0) begin
         n_fail++;
         $display("FAIL %s_writes_missing got %0d pending required 0", name,
                  nb ? q1.size() : q0.size());
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus0.busy, bus0.done, bus0.W, bus0.WADD, bus0.DIN} !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got %h required 0000",
                  {bus0.busy, bus0.done, bus0.W, bus0.WADD, bus0.DIN});
      end
      n_checks++;
      if ({bus1.busy, bus1.done, bus1.W, bus1.WADD, bus1.DIN} !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_outputs_nb got %h required 0000",
                  {bus1.busy, bus1.done, bus1.W, bus1.WADD, bus1.DIN});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_values;
      run_num(1'b0, 16'd0, 5'd0, "zero");
      run_num(1'b0, 16'd65535, 5'd16, "max");
      run_num(1'b0, 16'd12345, 5'd30, "wrap");
      run_num(1'b1, 16'd42, 5'd5, "noblank42");
      run_num(1'b0, 16'd42, 5'd5, "blank42");
      run_num(1'b0, 16'd1000, 5'd10, "inner_zeros");
   endtask

   task automatic test_back_to_back;
      run_num(1'b0, 16'd9, 5'd3, "b2b_a");
      run_num(1'b0, 16'd90210, 5'd28, "b2b_b");
   endtask

   // start re-asserted during CONV and on the DONE cycle must be ignored.
   task automatic test_ignore_start;
      int cyc;
      int d0;
      push_exp(1'b0, 100, 5'd12, 5);
      d0 = done0;
      drive_start(1'b0, 16'd100, 5'd12);
      cyc = 0;
      while (bus0.busy && cyc < 200) begin
         cyc++;
         bus0.start = 1'b0;
         if (cyc == 2) begin bus0.start = 1'b1; bus0.value = 16'd999; end
         if (bus0.done) begin bus0.start = 1'b1; bus0.value = 16'd999; end
         @(negedge clk);
      end
      bus0.start = 1'b0;
      repeat (40) @(negedge clk);
      n_checks++;
      if (cyc != 12) begin
         n_fail++;
         $display("FAIL ignore_busy_cycles got %0d required 12", cyc);
      end
      n_checks++;
      if (done0 - d0 != 1) begin
         n_fail++;
         $display("FAIL ignore_done_pulses got %0d required 1", done0 - d0);
      end
      n_checks++;
      if (q0.size() != 0) begin
         n_fail++;
         $display("FAIL ignore_writes_missing got %0d pending required 0", q0.size());
      end
   endtask

   // Reset in the third write cycle: three chars land, then everything stops.
   task automatic test_reset_mid;
      int wc;
      int guard;
      int d0;
      push_exp(1'b0, 54321, 5'd20, 3);
      drive_start(1'b0, 16'd54321, 5'd20);
      wc = 0;
      guard = 0;
      while (wc < 3 && guard < 200) begin
         if (bus0.W) wc++;
         if (wc < 3) @(negedge clk);
         guard++;
      end
      n_checks++;
      if (wc != 3) begin
         n_fail++;
         $display("FAIL resetmid_reach_write3 got %0d writes required 3", wc);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if ({bus0.busy, bus0.done, bus0.W, bus0.WADD, bus0.DIN} !== 16'd0) begin
         n_fail++;
         $display("FAIL resetmid_outputs got %h required 0000",
                  {bus0.busy, bus0.done, bus0.W, bus0.WADD, bus0.DIN});
      end
      d0 = done0;
      repeat (20) @(negedge clk);
      n_checks++;
      if (done0 != d0 || bus0.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL resetmid_quiet got done=%0d busy=%b required done=0 busy=0",
                  done0 - d0, bus0.busy);
      end
      n_checks++;
      if (q0.size() != 0) begin
         n_fail++;
         $display("FAIL resetmid_writes_missing got %0d pending required 0", q0.size());
      end
      run_num(1'b0, 16'd7, 5'd0, "after_reset");
   endtask

   initial begin
      rst_n      = 1'b0;
      bus0.start = 1'b0;
      bus0.value = '0;
      bus0.pos   = '0;
      bus1.start = 1'b0;
      bus1.value = '0;
      bus1.pos   = '0;
      test_reset();
      test_values();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid();
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
